// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave: FSM state encoding,
// pin synchronizer depth and the header length (read/write bit + address).
package spi_slave_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        WRITE_DATA,
        READ_DATA
    } state_e;

    localparam int SYNC_STAGES = 2;
    localparam int HEADER_BITS = 16;

endpackage

// File: rtl/spi_slave_if.sv
// Serial pins and local register port of the SPI slave, bundled with
// modports for the slave itself and for whatever drives the serial side.
interface spi_slave_if
    import spi_slave_pkg::*;
#(
    parameter int DATA_WIDTH    = HEADER_BITS,
    parameter int ADDRESS_WIDTH = HEADER_BITS - 1
);
    logic                     clock_polarity;
    logic                     clock_phase;
    logic                     serial_clock;
    logic                     chip_select;
    logic                     serial_in;
    logic [DATA_WIDTH-1:0]    read_data;
    logic                     serial_out;
    logic                     serial_out_enable;
    logic                     write_enable;
    logic [ADDRESS_WIDTH-1:0] write_address;
    logic [DATA_WIDTH-1:0]    write_data;
    logic                     read_request;
    logic [ADDRESS_WIDTH-1:0] read_address;
    logic                     busy;
    logic                     frame_error;

    modport slave (
        input  clock_polarity, clock_phase, serial_clock, chip_select, serial_in, read_data,
        output serial_out, serial_out_enable, write_enable, write_address, write_data,
               read_request, read_address, busy, frame_error
    );

    modport master (
        output clock_polarity, clock_phase, serial_clock, chip_select, serial_in, read_data,
        input  serial_out, serial_out_enable, write_enable, write_address, write_data,
               read_request, read_address, busy, frame_error
    );
endinterface

// File: rtl/spi_slave_edge_detector.sv
// Synchronizes SCLK, chip select and MOSI into the system clock domain and
// turns SCLK transitions into sample/shift strobes for the selected CPOL/CPHA.
// All strobes are registered: they appear 3 system clocks after the pin edge.
module spi_slave_edge_detector
    import spi_slave_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic clock_polarity,
    input  logic clock_phase,
    input  logic serial_clock,
    input  logic chip_select,
    input  logic serial_in,
    output logic sample_strobe,
    output logic shift_strobe,
    output logic cs_fall,
    output logic cs_rise,
    output logic serial_in_sync
);
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    logic sclk_prev_q, sclk_prev_d;
    logic cs_prev_q, cs_prev_d;
    logic sdi_q, sdi_d;
    logic sample_q, sample_d;
    logic shift_q, shift_d;
    logic cs_fall_q, cs_fall_d;
    logic cs_rise_q, cs_rise_d;
    logic sclk_s, cs_s, sclk_rise, sclk_fall, leading, trailing;

    // Advance the synchronizers and decode leading/trailing edges into strobes
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], serial_clock};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], chip_select};
        sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0], serial_in};
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        sdi_d       = sdi_sync_q[SYNC_STAGES-1];
        sclk_rise   = sclk_s & ~sclk_prev_q;
        sclk_fall   = ~sclk_s & sclk_prev_q;
        leading     = clock_polarity ? sclk_fall : sclk_rise;
        trailing    = clock_polarity ? sclk_rise : sclk_fall;
        sample_d    = clock_phase ? trailing : leading;
        shift_d     = clock_phase ? leading : trailing;
        cs_fall_d   = ~cs_s & cs_prev_q;
        cs_rise_d   = cs_s & ~cs_prev_q;
    end

    // Chip select history resets low so a select still held after reset is never seen as a new fall
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            sdi_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
            sdi_q       <= 1'b0;
            sample_q    <= 1'b0;
            shift_q     <= 1'b0;
            cs_fall_q   <= 1'b0;
            cs_rise_q   <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            sdi_sync_q  <= sdi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            sdi_q       <= sdi_d;
            sample_q    <= sample_d;
            shift_q     <= shift_d;
            cs_fall_q   <= cs_fall_d;
            cs_rise_q   <= cs_rise_d;
        end
    end

    assign sample_strobe  = sample_q;
    assign shift_strobe   = shift_q;
    assign cs_fall        = cs_fall_q;
    assign cs_rise        = cs_rise_q;
    assign serial_in_sync = sdi_q;
endmodule

// File: rtl/spi_slave.sv
// SPI slave: decodes {rd/wr bit, address, data words...} frames (MSB first)
// into write strobes and read requests on a local register port.
// Build option SPI_SLAVE_BURST_EN: when defined, frames carry any number of
// auto-incrementing data words; otherwise exactly one word is accepted and
// the rest of the frame is ignored.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int DATA_WIDTH    = HEADER_BITS,
    parameter int ADDRESS_WIDTH = HEADER_BITS - 1
) (
    input  logic       clock,
    input  logic       reset,
    spi_slave_if.slave bus
);
`ifdef SPI_SLAVE_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic sample_strobe, shift_strobe, cs_fall, cs_rise, sdi;
    state_e state_q, state_d;
    logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-2:0]    rx_q, rx_d;
    logic [DATA_WIDTH-1:0]    tx_q, tx_d, hold_q, hold_d, write_data_q, write_data_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d, write_address_q, write_address_d;
    logic [ADDRESS_WIDTH-1:0] read_address_q, read_address_d;
    logic write_enable_q, write_enable_d, read_request_q, read_request_d;
    logic capture_q, capture_d, frame_error_q, frame_error_d, done_q, done_d;
    logic [DATA_WIDTH-1:0]    word;
    logic                     last_bit;

    spi_slave_edge_detector u_edge (
        .clock          (clock),
        .reset          (reset),
        .clock_polarity (bus.clock_polarity),
        .clock_phase    (bus.clock_phase),
        .serial_clock   (bus.serial_clock),
        .chip_select    (bus.chip_select),
        .serial_in      (bus.serial_in),
        .sample_strobe  (sample_strobe),
        .shift_strobe   (shift_strobe),
        .cs_fall        (cs_fall),
        .cs_rise        (cs_rise),
        .serial_in_sync (sdi)
    );

    // Frame FSM: bit counting, header/word decode, local-port strobes and MISO shifter
    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        rx_d            = rx_q;
        tx_d            = tx_q;
        hold_d          = hold_q;
        addr_d          = addr_q;
        write_address_d = write_address_q;
        write_data_d    = write_data_q;
        read_address_d  = read_address_q;
        write_enable_d  = 1'b0;
        read_request_d  = 1'b0;
        frame_error_d   = 1'b0;
        done_d          = done_q;
        capture_d       = read_request_q;
        word            = {rx_q, sdi};
        last_bit        = (bit_cnt_q == LAST_BIT);

        // read_data is valid the cycle after the request
        if (capture_q) hold_d = bus.read_data;

        if (state_q == IDLE) begin
            if (cs_fall) begin
                state_d   = HEADER;
                bit_cnt_d = '0;
                done_d    = 1'b0;
                tx_d      = '0;
            end
        end else if (cs_rise) begin
            state_d       = IDLE;
            frame_error_d = (bit_cnt_q != '0);
        end else if (!done_q) begin
            if (sample_strobe) begin
                rx_d      = word[DATA_WIDTH-2:0];
                bit_cnt_d = last_bit ? '0 : bit_cnt_q + CNT_W'(1);
                if (last_bit) begin
                    case (state_q)
                        HEADER: begin
                            if (word[DATA_WIDTH-1]) begin
                                // Prefetch the first read word right away
                                state_d        = READ_DATA;
                                read_request_d = 1'b1;
                                read_address_d = word[ADDRESS_WIDTH-1:0];
                                addr_d         = word[ADDRESS_WIDTH-1:0] + ADDRESS_WIDTH'(1);
                            end else begin
                                state_d = WRITE_DATA;
                                addr_d  = word[ADDRESS_WIDTH-1:0];
                            end
                        end
                        WRITE_DATA: begin
                            write_enable_d  = 1'b1;
                            write_address_d = addr_q;
                            write_data_d    = word;
                            addr_d          = addr_q + ADDRESS_WIDTH'(1);
                            done_d          = !BURST;
                        end
                        READ_DATA: begin
                            if (BURST) begin
                                read_request_d = 1'b1;
                                read_address_d = addr_q;
                                addr_d         = addr_q + ADDRESS_WIDTH'(1);
                            end else begin
                                done_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            // A shift at a word boundary loads the prefetched word, otherwise advance the MSB
            if (shift_strobe && state_q == READ_DATA) begin
                tx_d = (bit_cnt_q == '0) ? hold_q : {tx_q[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            bit_cnt_q       <= '0;
            rx_q            <= '0;
            tx_q            <= '0;
            hold_q          <= '0;
            addr_q          <= '0;
            write_address_q <= '0;
            write_data_q    <= '0;
            read_address_q  <= '0;
            write_enable_q  <= 1'b0;
            read_request_q  <= 1'b0;
            capture_q       <= 1'b0;
            frame_error_q   <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            rx_q            <= rx_d;
            tx_q            <= tx_d;
            hold_q          <= hold_d;
            addr_q          <= addr_d;
            write_address_q <= write_address_d;
            write_data_q    <= write_data_d;
            read_address_q  <= read_address_d;
            write_enable_q  <= write_enable_d;
            read_request_q  <= read_request_d;
            capture_q       <= capture_d;
            frame_error_q   <= frame_error_d;
            done_q          <= done_d;
        end
    end

    assign bus.serial_out        = (state_q == READ_DATA) && !done_q && tx_q[DATA_WIDTH-1];
    assign bus.serial_out_enable = (state_q != IDLE);
    assign bus.busy              = (state_q != IDLE);
    assign bus.write_enable      = write_enable_q;
    assign bus.write_address     = write_address_q;
    assign bus.write_data        = write_data_q;
    assign bus.read_request      = read_request_q;
    assign bus.read_address      = read_address_q;
    assign bus.frame_error       = frame_error_q;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a table of complete SPI frames in all four modes,
// followed by a reset-mid-frame sequence and a clean recovery frame.
module tb_spi_slave;
    localparam int H = 6;  // SCLK half period in system clocks

`ifdef SPI_SLAVE_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    typedef struct packed {
        logic             cpol;
        logic             cpha;
        logic [63:0]      tx;
        int               nbits;
        logic             xor_mem;
        logic [15:0]      rd_const;
        int               exp_wr;
        logic [2:0][14:0] exp_wa;
        logic [2:0][15:0] exp_wd;
        int               exp_rd;
        logic [2:0][14:0] exp_ra;
        logic [63:0]      exp_rx;
        int               exp_fe;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    spi_slave_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(15)) bus ();

    spi_slave #(.DATA_WIDTH(16), .ADDRESS_WIDTH(15)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic        mem_xor   = 1'b0;
    logic [15:0] mem_const = 16'h0000;

    // Local memory: answers one cycle after each request
    always @(posedge clock)
        if (bus.read_request)
            bus.read_data <= mem_xor ? ({1'b0, bus.read_address} ^ 16'hFFFF) : mem_const;

    logic [14:0] wr_a[$];
    logic [15:0] wr_d[$];
    logic [14:0] rd_a[$];
    int          fe_cnt = 0;

    // Record every strobe cycle on the local port
    always @(negedge clock) begin
        if (bus.write_enable) begin
            wr_a.push_back(bus.write_address);
            wr_d.push_back(bus.write_data);
        end
        if (bus.read_request) rd_a.push_back(bus.read_address);
        if (bus.frame_error) fe_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " serial_out"}, bus.serial_out, 0);
        chk({tag, " serial_out_enable"}, bus.serial_out_enable, 0);
        chk({tag, " write_enable"}, bus.write_enable, 0);
        chk({tag, " read_request"}, bus.read_request, 0);
        chk({tag, " busy"}, bus.busy, 0);
        chk({tag, " frame_error"}, bus.frame_error, 0);
        chk({tag, " write_address"}, bus.write_address, 0);
        chk({tag, " read_address"}, bus.read_address, 0);
        chk({tag, " write_data"}, bus.write_data, 0);
    endtask

    // SPI master: shifts out tx[63:64-nbits] MSB first, captures MISO into rx
    task automatic spi_xfer(input logic cpol, input logic cpha, input logic [63:0] tx,
                            input int nbits, output logic [63:0] rx, output logic busy_ok);
        rx = '0;
        busy_ok = 1'b1;
        bus.clock_polarity = cpol;
        bus.clock_phase    = cpha;
        bus.serial_clock   = cpol;
        bus.serial_in      = 1'b0;
        repeat (H) @(negedge clock);
        bus.chip_select = 1'b0;
        if (!cpha) bus.serial_in = tx[63];
        repeat (H) @(negedge clock);
        for (int i = 0; i < nbits; i++) begin
            busy_ok &= bus.busy & bus.serial_out_enable;
            if (!cpha) begin
                rx[63-i] = bus.serial_out;
                bus.serial_clock = ~cpol;
                repeat (H) @(negedge clock);
                bus.serial_clock = cpol;
                if (i < 63) bus.serial_in = tx[62-i];
            end else begin
                bus.serial_clock = ~cpol;
                bus.serial_in = tx[63-i];
                repeat (H) @(negedge clock);
                bus.serial_clock = cpol;
                rx[63-i] = bus.serial_out;
            end
            repeat (H) @(negedge clock);
        end
        bus.chip_select = 1'b1;
        bus.serial_in   = 1'b0;
        repeat (4 * H) @(negedge clock);
    endtask

    vec_t        vecs[7];
    logic [63:0] rx, rx2;
    logic        busy_ok, busy_ok2;
    int          wb, rb, fb;

    initial begin
        for (int v = 0; v < 7; v++) vecs[v] = '0;
        // Mode 0 single write
        vecs[0].tx = {16'h1111, 16'hA5C3, 32'h0}; vecs[0].nbits = 32;
        vecs[0].exp_wr = 1; vecs[0].exp_wa[0] = 15'h1111; vecs[0].exp_wd[0] = 16'hA5C3;
        // Mode 3 read at 0x0042
        vecs[1].cpol = 1; vecs[1].cpha = 1; vecs[1].tx = {16'h8042, 48'h0}; vecs[1].nbits = 32;
        vecs[1].rd_const = 16'hBEEF; vecs[1].exp_rd = BURST ? 2 : 1;
        vecs[1].exp_ra[0] = 15'h0042; vecs[1].exp_ra[1] = 15'h0043;
        vecs[1].exp_rx = {16'h0, 16'hBEEF, 32'h0};
        // Mode 1 three-word write across the address wrap
        vecs[2].cpha = 1; vecs[2].tx = {16'h7FFE, 16'h1111, 16'h2222, 16'h3333}; vecs[2].nbits = 64;
        vecs[2].exp_wr = BURST ? 3 : 1;
        vecs[2].exp_wa[0] = 15'h7FFE; vecs[2].exp_wa[1] = 15'h7FFF; vecs[2].exp_wa[2] = 15'h0000;
        vecs[2].exp_wd[0] = 16'h1111; vecs[2].exp_wd[1] = 16'h2222; vecs[2].exp_wd[2] = 16'h3333;
        // Mode 2 two-word read at 0x0010, memory returns address ^ 0xFFFF
        vecs[3].cpol = 1; vecs[3].tx = {16'h8010, 48'h0}; vecs[3].nbits = 48; vecs[3].xor_mem = 1;
        vecs[3].exp_rd = BURST ? 3 : 1;
        vecs[3].exp_ra[0] = 15'h0010; vecs[3].exp_ra[1] = 15'h0011; vecs[3].exp_ra[2] = 15'h0012;
        vecs[3].exp_rx = BURST ? {16'h0, 16'hFFEF, 16'hFFEE, 16'h0} : {16'h0, 16'hFFEF, 32'h0};
        // Mode 0 write cut after 8 data bits
        vecs[4].tx = {16'h0123, 8'hAB, 40'h0}; vecs[4].nbits = 24; vecs[4].exp_fe = 1;
        // Mode 1 read frame with header only: one request, no error
        vecs[5].cpha = 1; vecs[5].tx = {16'h8005, 48'h0}; vecs[5].nbits = 16; vecs[5].rd_const = 16'h1234;
        vecs[5].exp_rd = 1; vecs[5].exp_ra[0] = 15'h0005;
        // Mode 2 read cut after 4 data bits
        vecs[6].cpol = 1; vecs[6].tx = {16'h8020, 48'h0}; vecs[6].nbits = 20; vecs[6].xor_mem = 1;
        vecs[6].exp_rd = 1; vecs[6].exp_ra[0] = 15'h0020; vecs[6].exp_fe = 1;
        vecs[6].exp_rx = {16'h0, 4'hF, 44'h0};

        bus.clock_polarity = 1'b0;
        bus.clock_phase    = 1'b0;
        bus.serial_clock   = 1'b0;
        bus.chip_select    = 1'b1;
        bus.serial_in      = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_values("initial reset");
        reset = 1'b0;
        repeat (4) @(negedge clock);

        for (int v = 0; v < 7; v++) begin
            wb = wr_a.size(); rb = rd_a.size(); fb = fe_cnt;
            mem_xor   = vecs[v].xor_mem;
            mem_const = vecs[v].rd_const;
            spi_xfer(vecs[v].cpol, vecs[v].cpha, vecs[v].tx, vecs[v].nbits, rx, busy_ok);
            chk($sformatf("v%0d write count", v), wr_a.size() - wb, vecs[v].exp_wr);
            for (int i = 0; i < vecs[v].exp_wr && wb + i < wr_a.size(); i++) begin
                chk($sformatf("v%0d write_address[%0d]", v, i), wr_a[wb+i], vecs[v].exp_wa[i]);
                chk($sformatf("v%0d write_data[%0d]", v, i), wr_d[wb+i], vecs[v].exp_wd[i]);
            end
            chk($sformatf("v%0d read count", v), rd_a.size() - rb, vecs[v].exp_rd);
            for (int i = 0; i < vecs[v].exp_rd && rb + i < rd_a.size(); i++)
                chk($sformatf("v%0d read_address[%0d]", v, i), rd_a[rb+i], vecs[v].exp_ra[i]);
            chk($sformatf("v%0d miso bits", v), rx, vecs[v].exp_rx);
            chk($sformatf("v%0d frame_error count", v), fe_cnt - fb, vecs[v].exp_fe);
            chk($sformatf("v%0d busy in frame", v), busy_ok, 1);
            chk($sformatf("v%0d busy after", v), bus.busy, 0);
            chk($sformatf("v%0d serial_out_enable after", v), bus.serial_out_enable, 0);
        end

        // Reset in the middle of a write header; the rest of that frame must be ignored
        wb = wr_a.size(); rb = rd_a.size(); fb = fe_cnt;
        fork
            spi_xfer(1'b0, 1'b0, {16'h0ABC, 16'h5555, 32'h0}, 32, rx2, busy_ok2);
            begin
                repeat (2 * H + 10 * H) @(negedge clock);
                reset = 1'b1;
                repeat (3) @(negedge clock);
                check_reset_values("mid-frame reset");
                reset = 1'b0;
            end
        join
        chk("aborted frame write count", wr_a.size() - wb, 0);
        chk("aborted frame read count", rd_a.size() - rb, 0);
        chk("aborted frame frame_error count", fe_cnt - fb, 0);
        chk("aborted frame busy after", bus.busy, 0);

        // Clean write after the reset
        wb = wr_a.size(); fb = fe_cnt;
        spi_xfer(1'b0, 1'b0, {16'h2468, 16'h9ABC, 32'h0}, 32, rx, busy_ok);
        chk("recovery write count", wr_a.size() - wb, 1);
        if (wr_a.size() > wb) begin
            chk("recovery write_address", wr_a[wb], 15'h2468);
            chk("recovery write_data", wr_d[wb], 16'h9ABC);
        end
        chk("recovery frame_error count", fe_cnt - fb, 0);
        chk("recovery busy in frame", busy_ok, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
